// File: rtl/sram_req_arbiter.sv
// Shares one sram-like port between the inst and data requesters.
// The address phase is granted data-first and held until the slave accepts it.
// Accepted request IDs go into an in-order FIFO that routes each response back.
module sram_req_arbiter #(
  parameter int unsigned OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic [2:0]  outstanding,
  output logic        protocol_err
);

  localparam int unsigned PTR_W = 3;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(OUTSTANDING - 1);
  localparam logic [PTR_W-1:0] CAPACITY = PTR_W'(OUTSTANDING);

  // ID encoding: 0 = inst, 1 = data
  logic             lock_vld;
  logic             lock_id;
  logic             id_fifo [8];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] count;

  logic grant_vld;
  logic grant_id;
  logic granted_req;
  logic full;
  logic push;
  logic pop;
  logic head_id;

  // Grant selection: a held lock wins, otherwise data before inst
  always_comb begin
    grant_vld   = lock_vld | data_sram_req | inst_sram_req;
    grant_id    = lock_vld ? lock_id : data_sram_req;
    granted_req = grant_vld & (grant_id ? data_sram_req : inst_sram_req);
    full        = (count == CAPACITY);
    mem_req     = granted_req & ~full;
    push        = mem_req & mem_addr_ok;
    pop         = mem_data_ok & (count != '0);
    head_id     = id_fifo[rd_ptr];
  end

  // Request field mux toward the slave; zero when nobody is granted
  always_comb begin
    mem_wr    = 1'b0;
    mem_size  = 2'd0;
    mem_wstrb = 4'd0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    if (grant_vld) begin
      if (grant_id) begin
        mem_wr    = data_sram_wr;
        mem_size  = data_sram_size;
        mem_wstrb = data_sram_wstrb;
        mem_addr  = data_sram_addr;
        mem_wdata = data_sram_wdata;
      end else begin
        mem_wr    = inst_sram_wr;
        mem_size  = inst_sram_size;
        mem_wstrb = inst_sram_wstrb;
        mem_addr  = inst_sram_addr;
        mem_wdata = inst_sram_wdata;
      end
    end
  end

  // Handshake and response routing back to the requesters
  always_comb begin
    inst_sram_addr_ok = push & ~grant_id;
    data_sram_addr_ok = push & grant_id;
    inst_sram_data_ok = pop & ~head_id;
    data_sram_data_ok = pop & head_id;
    inst_sram_rdata   = mem_rdata;
    data_sram_rdata   = mem_rdata;
    outstanding       = count;
  end

  // Grant lock: keep a presented-but-unaccepted request on the bus
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_vld <= 1'b0;
      lock_id  <= 1'b0;
    end else if (push) begin
      lock_vld <= 1'b0;
    end else if (mem_req) begin
      lock_vld <= 1'b1;
      lock_id  <= grant_id;
    end else if (lock_vld && !granted_req) begin
      lock_vld <= 1'b0;
    end
  end

  // In-order ID FIFO of accepted requests
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) id_fifo[i] <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        id_fifo[wr_ptr] <= grant_id;
        wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + PTR_W'(1);
      end else if (pop && !push) begin
        count <= count - PTR_W'(1);
      end
    end
  end

  // Sticky flag for a slave response with nothing outstanding
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      protocol_err <= 1'b0;
    end else if (mem_data_ok && (count == '0)) begin
      protocol_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Scoreboard bench for sram_req_arbiter: directed cycles push expected
// accepts/responses, a negedge monitor pops and compares them.
module tb_sram_req_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic [2:0]  outstanding;
  logic        protocol_err;

  typedef struct {
    logic        id;
    logic [31:0] val;
  } exp_t;

  exp_t exp_acc[$];
  exp_t exp_rsp[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_req_arbiter #(.OUTSTANDING(2)) dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .outstanding(outstanding), .protocol_err(protocol_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One bus cycle: drive just after the edge, return 1 time unit later
  task automatic cyc(input logic ireq, input logic [31:0] iaddr,
                     input logic dreq, input logic [31:0] daddr,
                     input logic aok, input logic dok, input logic [31:0] rdata);
    @(posedge clk);
    #1;
    inst_sram_req  = ireq;
    inst_sram_addr = iaddr;
    data_sram_req  = dreq;
    data_sram_addr = daddr;
    data_sram_wdata = ~daddr;
    mem_addr_ok    = aok;
    mem_data_ok    = dok;
    mem_rdata      = rdata;
    #1;
  endtask

  function automatic void exp_a(input logic id, input logic [31:0] addr);
    exp_t e;
    e.id = id;
    e.val = addr;
    exp_acc.push_back(e);
  endfunction

  function automatic void exp_r(input logic id, input logic [31:0] rdata);
    exp_t e;
    e.id = id;
    e.val = rdata;
    exp_rsp.push_back(e);
  endfunction

  // Monitor: compare every handshake the DUT presents against the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (inst_sram_addr_ok || data_sram_addr_ok) begin
        check("addr_ok_exclusive", 32'(inst_sram_addr_ok & data_sram_addr_ok), 32'd0);
        if (exp_acc.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL acc_unexpected actual_id=%0d required=none", data_sram_addr_ok);
        end else begin
          e = exp_acc.pop_front();
          check("acc_id", 32'(data_sram_addr_ok), 32'(e.id));
          check("acc_addr", mem_addr, e.val);
          check("acc_wr", 32'(mem_wr), 32'(e.id));
        end
      end
      if (inst_sram_data_ok || data_sram_data_ok) begin
        check("data_ok_exclusive", 32'(inst_sram_data_ok & data_sram_data_ok), 32'd0);
        if (exp_rsp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected actual_id=%0d required=none", data_sram_data_ok);
        end else begin
          e = exp_rsp.pop_front();
          check("rsp_id", 32'(data_sram_data_ok), 32'(e.id));
          check("rsp_rdata", e.id ? data_sram_rdata : inst_sram_rdata, e.val);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 2'd2; inst_sram_wstrb = 4'hf;
    inst_sram_addr = 0; inst_sram_wdata = 0;
    data_sram_req = 0; data_sram_wr = 1; data_sram_size = 2'd2; data_sram_wstrb = 4'hf;
    data_sram_addr = 0; data_sram_wdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_outstanding", 32'(outstanding), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_protocol_err", 32'(protocol_err), 32'd0);
    reset = 1'b0;

    // 1: both request in idle -> data first, then inst; responses in order
    cyc(1, 32'h1000_0000, 1, 32'h2000_0000, 1, 0, 0); exp_a(1, 32'h2000_0000);
    cyc(1, 32'h1000_0000, 0, 0, 1, 0, 0);             exp_a(0, 32'h1000_0000);
    cyc(0, 0, 0, 0, 0, 1, 32'haaaa_0001);             exp_r(1, 32'haaaa_0001);
    check("t1_outstanding2", 32'(outstanding), 32'd2);
    cyc(0, 0, 0, 0, 0, 1, 32'haaaa_0002);             exp_r(0, 32'haaaa_0002);
    check("t1_outstanding1", 32'(outstanding), 32'd1);

    // 2: stalled inst request keeps the bus even when data arrives
    cyc(1, 32'h1000_0010, 0, 0, 0, 0, 0);
    check("t2_req", 32'(mem_req), 32'd1);
    check("t2_addr0", mem_addr, 32'h1000_0010);
    cyc(1, 32'h1000_0010, 1, 32'h2000_0010, 0, 0, 0);
    check("t2_addr1", mem_addr, 32'h1000_0010);
    cyc(1, 32'h1000_0010, 1, 32'h2000_0010, 0, 0, 0);
    check("t2_addr2", mem_addr, 32'h1000_0010);
    cyc(1, 32'h1000_0010, 1, 32'h2000_0010, 1, 0, 0); exp_a(0, 32'h1000_0010);
    cyc(0, 0, 1, 32'h2000_0010, 1, 0, 0);             exp_a(1, 32'h2000_0010);
    cyc(0, 0, 0, 0, 0, 1, 32'hbbbb_0001);             exp_r(0, 32'hbbbb_0001);
    cyc(0, 0, 0, 0, 0, 1, 32'hbbbb_0002);             exp_r(1, 32'hbbbb_0002);

    // 3: FIFO full blocks mem_req until a response frees a slot
    cyc(1, 32'h1000_0020, 0, 0, 1, 0, 0);             exp_a(0, 32'h1000_0020);
    cyc(1, 32'h1000_0024, 0, 0, 1, 0, 0);             exp_a(0, 32'h1000_0024);
    cyc(1, 32'h1000_0028, 0, 0, 1, 0, 0);
    check("t3_full_req", 32'(mem_req), 32'd0);
    check("t3_full_cnt", 32'(outstanding), 32'd2);
    cyc(1, 32'h1000_0028, 0, 0, 1, 1, 32'hcccc_0001); exp_r(0, 32'hcccc_0001);
    check("t3_full_pop_req", 32'(mem_req), 32'd0);
    cyc(1, 32'h1000_0028, 0, 0, 1, 0, 0);             exp_a(0, 32'h1000_0028);
    check("t3_reissue_req", 32'(mem_req), 32'd1);

    // 4: simultaneous push and pop at count 1 keeps order
    cyc(0, 0, 0, 0, 0, 1, 32'hdddd_0001);             exp_r(0, 32'hdddd_0001);
    cyc(0, 0, 1, 32'h2000_0030, 1, 1, 32'hdddd_0002);
    exp_a(1, 32'h2000_0030);
    exp_r(0, 32'hdddd_0002);
    check("t4_cnt_before", 32'(outstanding), 32'd1);
    cyc(0, 0, 0, 0, 0, 1, 32'hdddd_0003);             exp_r(1, 32'hdddd_0003);
    check("t4_cnt_after", 32'(outstanding), 32'd1);

    // 5: response with nothing outstanding
    cyc(0, 0, 0, 0, 0, 1, 32'heeee_0001);
    check("t5_cnt", 32'(outstanding), 32'd0);
    check("t5_inst_data_ok", 32'(inst_sram_data_ok), 32'd0);
    check("t5_data_data_ok", 32'(data_sram_data_ok), 32'd0);
    check("t5_err_pre", 32'(protocol_err), 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("t5_err_set", 32'(protocol_err), 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("t5_err_hold", 32'(protocol_err), 32'd1);

    // 6: async reset mid-cycle with one outstanding and a lock held
    cyc(1, 32'h1000_0040, 0, 0, 1, 0, 0);             exp_a(0, 32'h1000_0040);
    cyc(1, 32'h1000_0044, 0, 0, 0, 0, 0);
    cyc(1, 32'h1000_0044, 1, 32'h2000_0044, 0, 0, 0);
    check("t6_locked_addr", mem_addr, 32'h1000_0044);
    check("t6_cnt_pre", 32'(outstanding), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("t6_rst_cnt", 32'(outstanding), 32'd0);
    check("t6_rst_err", 32'(protocol_err), 32'd0);
    check("t6_rst_unlock", mem_addr, 32'h2000_0044);
    reset = 1'b0;
    cyc(0, 0, 0, 0, 0, 1, 32'hffff_0001);
    check("t6_late_data_ok", 32'(inst_sram_data_ok | data_sram_data_ok), 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("t6_late_err", 32'(protocol_err), 32'd1);

    repeat (2) @(posedge clk);
    #1;
    check("acc_queue_drained", 32'(exp_acc.size()), 32'd0);
    check("rsp_queue_drained", 32'(exp_rsp.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
